// File: rtl/pe_array_ctrl_pkg.sv
// Shared types for the PE-array layer controller.
//   op_mode_t    : layer operating mode broadcast to the PEs
//   op_stage_t   : stage indication broadcast to the PEs
//   ctrl_state_t : controller FSM state (exported so benches can name it)
package pe_array_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE1 = 2'd0,
    MODE2 = 2'd1,
    MODE3 = 2'd2,
    MODE4 = 2'd3
  } op_mode_t;

  typedef enum logic [1:0] {
    STAGE_IDLE        = 2'd0,
    STAGE_LOAD_FILTER = 2'd1,
    STAGE_CONV        = 2'd2
  } op_stage_t;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    LOAD,
    KICK,
    WAIT,
    FIN,
    ERR
  } ctrl_state_t;

  localparam int unsigned ROUND_CNT_W = 16;

  // Watchdog counter width able to hold the value TIMEOUT.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Bundle between the layer controller, the layer scheduler and the PE array /
// filter buffer.
//   master : controller view (drives mode/stage/pulses/status)
//   slave  : scheduler + PE array view (drives start/abort/config/PE status)
interface pe_array_ctrl_if import pe_array_ctrl_pkg::*; #(
  parameter int unsigned NUM_PE = 4
) ();

  // scheduler -> controller
  logic                   start;
  logic                   abort;
  op_mode_t               mode_cfg;
  // filter buffer / PEs -> controller
  logic                   fload_done;
  logic [NUM_PE-1:0]      conv_done;
  logic [NUM_PE-1:0]      pe_error;
  // controller -> PEs / filter buffer
  op_mode_t               mode;
  logic                   change_mode;
  op_stage_t              op_stage;
  logic                   fload_start;
  logic                   conv_continue;
  // controller -> scheduler
  logic [ROUND_CNT_W-1:0] round_cnt;
  logic                   busy;
  logic                   layer_done;
  logic                   fault;

  modport master (
    input  start, abort, mode_cfg, fload_done, conv_done, pe_error,
    output mode, change_mode, op_stage, fload_start, conv_continue,
           round_cnt, busy, layer_done, fault
  );

  modport slave (
    output start, abort, mode_cfg, fload_done, conv_done, pe_error,
    input  mode, change_mode, op_stage, fload_start, conv_continue,
           round_cnt, busy, layer_done, fault
  );

endinterface

// File: rtl/pe_array_ctrl_watchdog.sv
// Per-round watchdog counter.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the count from zero
//   enable   : count this cycle
//   limit    : number of enabled cycles allowed
//   expired  : high during the limit-th enabled cycle since clear
module ctrl_watchdog #(
  parameter int unsigned WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;

  assign cnt_inc = cnt + WIDTH'(1);
  // Flagged in the cycle that would bring the count to limit, so the
  // registered fault follows exactly limit enabled cycles.
  assign expired = enable && (cnt_inc == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/pe_array_ctrl.sv
// Layer controller for a row of NUM_PE lock-step PEs: mode configuration,
// filter load, then ROUND_NUM convolution rounds, with per-PE completion
// aggregation, error collection and a per-round watchdog.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pe_array_ctrl_if master (start/abort/mode_cfg/fload_done/
//              conv_done/pe_error in; mode/change_mode/op_stage/fload_start/
//              conv_continue/round_cnt/busy/layer_done/fault out)
module pe_array_ctrl import pe_array_ctrl_pkg::*; #(
  parameter int unsigned NUM_PE    = 4,
  parameter int unsigned ROUND_NUM = 55,
  parameter int unsigned TIMEOUT   = 20000
) (
  input logic            clk,
  input logic            rst,
  pe_array_ctrl_if.master bus
);

  localparam int unsigned            WD_W       = wd_width(TIMEOUT);
  localparam logic [ROUND_CNT_W-1:0] LAST_ROUND = ROUND_CNT_W'(ROUND_NUM - 1);

  ctrl_state_t            state;
  op_mode_t               mode_q;
  op_stage_t              op_stage_q;
  logic                   change_mode_q;
  logic                   fload_start_q;
  logic                   conv_continue_q;
  logic                   layer_done_q;
  logic                   fault_q;
  logic [ROUND_CNT_W-1:0] round_cnt_q;

  logic [NUM_PE-1:0]      done_seen;
  logic [NUM_PE-1:0]      done_next;
  logic [1:0]             stale_cnt;
  logic                   wd_clear;
  logic                   wd_enable;
  logic                   wd_expired;

  // conv_done levels sampled in the continue-pulse cycle and the two after it
  // still belong to the previous round and are ignored.
  always_comb begin
    done_next = done_seen;
    if (stale_cnt == 2'd0) begin
      done_next = done_seen | bus.conv_done;
    end
  end

  assign wd_clear  = (state == KICK);
  assign wd_enable = (state == WAIT);

  ctrl_watchdog #(
    .WIDTH (WD_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (WD_W'(TIMEOUT)),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      mode_q          <= MODE1;
      op_stage_q      <= STAGE_IDLE;
      change_mode_q   <= 1'b0;
      fload_start_q   <= 1'b0;
      conv_continue_q <= 1'b0;
      layer_done_q    <= 1'b0;
      fault_q         <= 1'b0;
      round_cnt_q     <= '0;
      done_seen       <= '0;
      stale_cnt       <= '0;
    end else begin
      change_mode_q   <= 1'b0;
      fload_start_q   <= 1'b0;
      conv_continue_q <= 1'b0;
      layer_done_q    <= 1'b0;

      if (bus.abort) begin
        state       <= IDLE;
        op_stage_q  <= STAGE_IDLE;
        fault_q     <= 1'b0;
        round_cnt_q <= '0;
      end else if (state != IDLE && (|bus.pe_error)) begin
        state      <= ERR;
        op_stage_q <= STAGE_IDLE;
        fault_q    <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              state <= CFG;
              // Mode and its change pulse become visible together in CFG.
              if (bus.mode_cfg != mode_q) begin
                mode_q        <= bus.mode_cfg;
                change_mode_q <= 1'b1;
              end
            end
          end
          CFG: begin
            state         <= LOAD;
            op_stage_q    <= STAGE_LOAD_FILTER;
            fload_start_q <= 1'b1;
          end
          LOAD: begin
            // fload_done coinciding with the fload_start pulse is too early.
            if (bus.fload_done && !fload_start_q) begin
              state      <= KICK;
              op_stage_q <= STAGE_CONV;
            end
          end
          KICK: begin
            state           <= WAIT;
            conv_continue_q <= 1'b1;
            done_seen       <= '0;
            stale_cnt       <= 2'd3;
          end
          WAIT: begin
            if (stale_cnt != 2'd0) begin
              stale_cnt <= stale_cnt - 2'd1;
            end
            if (wd_expired) begin
              state      <= ERR;
              op_stage_q <= STAGE_IDLE;
              fault_q    <= 1'b1;
            end else if (&done_next) begin
              if (round_cnt_q == LAST_ROUND) begin
                state        <= FIN;
                op_stage_q   <= STAGE_IDLE;
                layer_done_q <= 1'b1;
                round_cnt_q  <= '0;
              end else begin
                state       <= KICK;
                round_cnt_q <= round_cnt_q + ROUND_CNT_W'(1);
              end
            end else begin
              done_seen <= done_next;
            end
          end
          FIN: begin
            state <= IDLE;
          end
          ERR: begin
            state <= ERR;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.mode          = mode_q;
  assign bus.change_mode   = change_mode_q;
  assign bus.op_stage      = op_stage_q;
  assign bus.fload_start   = fload_start_q;
  assign bus.conv_continue = conv_continue_q;
  assign bus.round_cnt     = round_cnt_q;
  assign bus.busy          = (state != IDLE);
  assign bus.layer_done    = layer_done_q;
  assign bus.fault         = fault_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl. Two instances share all inputs: dut_a with a short
// watchdog (100) and dut_b with a long one (1000) for the staggered-completion
// layer. Outputs are sampled 1 time unit after the rising edge.
module tb_pe_array_ctrl;
  import pe_array_ctrl_pkg::*;

  logic clk;
  logic rst;
  bit   sel;
  int   n_chk;
  int   n_fail;

  pe_array_ctrl_if #(.NUM_PE(4)) bus_a ();
  pe_array_ctrl_if #(.NUM_PE(4)) bus_b ();

  assign bus_b.start      = bus_a.start;
  assign bus_b.abort      = bus_a.abort;
  assign bus_b.mode_cfg   = bus_a.mode_cfg;
  assign bus_b.fload_done = bus_a.fload_done;
  assign bus_b.conv_done  = bus_a.conv_done;
  assign bus_b.pe_error   = bus_a.pe_error;

  pe_array_ctrl #(.NUM_PE(4), .ROUND_NUM(3), .TIMEOUT(100)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pe_array_ctrl #(.NUM_PE(4), .ROUND_NUM(3), .TIMEOUT(1000)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic        s_cc, s_ld, s_fault, s_busy;
  logic [15:0] s_round;
  op_stage_t   s_stg;

  assign s_cc    = sel ? bus_b.conv_continue : bus_a.conv_continue;
  assign s_ld    = sel ? bus_b.layer_done    : bus_a.layer_done;
  assign s_fault = sel ? bus_b.fault         : bus_a.fault;
  assign s_busy  = sel ? bus_b.busy          : bus_a.busy;
  assign s_round = sel ? bus_b.round_cnt     : bus_a.round_cnt;
  assign s_stg   = sel ? bus_b.op_stage      : bus_a.op_stage;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench time limit exceeded");
  end

  typedef struct {
    logic      st;
    logic      ab;
    op_mode_t  cfg;
    logic      fd;
    logic      cm;
    op_mode_t  md;
    op_stage_t stg;
    logic      fs;
    logic      cc;
    logic      busy;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(logic st, logic ab, op_mode_t cfg, logic fd,
                              logic cm, op_mode_t md, op_stage_t stg,
                              logic fs, logic cc, logic busy);
    vec_t v;
    v.st = st; v.ab = ab; v.cfg = cfg; v.fd = fd;
    v.cm = cm; v.md = md; v.stg = stg; v.fs = fs; v.cc = cc; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start -> CFG -> LOAD (fload_start) -> fload_done one cycle later -> KICK.
  task automatic begin_layer(input op_mode_t m);
    bus_a.start    = 1'b1;
    bus_a.mode_cfg = m;
    tick();
    bus_a.start = 1'b0;
    tick();
    tick();
    bus_a.fload_done = 1'b1;
    tick();
    bus_a.fload_done = 1'b0;
  endtask

  // Models four PEs raising conv_done d[i] cycles after each continue pulse.
  // PE1 drops its level briefly after raising it; every PE keeps its level
  // for the pulse cycle and the one after (stale level across continue).
  task automatic run_layer(input int d0, input int d1, input int d2, input int d3);
    int d [4];
    int maxd;
    int t, hold, pulses, layers, last_p, layer_cyc, budget;
    logic [3:0] cd;
    d = '{d0, d1, d2, d3};
    maxd = 0;
    for (int i = 0; i < 4; i++) if (d[i] > maxd) maxd = d[i];
    t = 0; hold = 0; pulses = 0; layers = 0; last_p = -1; layer_cyc = -1; cd = '0;
    budget = 3 * (maxd + 2) + 40;
    for (int cyc = 0; cyc < budget; cyc++) begin
      tick();
      if (s_cc) begin
        pulses++;
        chk($sformatf("round_cnt_at_continue_%0d", pulses), 32'(s_round), 32'(pulses - 1));
        if (last_p >= 0) chk("round_spacing", 32'(cyc - last_p), 32'(maxd + 2));
        last_p = cyc;
        t = 0;
        hold = 2;
      end else begin
        t++;
      end
      if (s_ld) begin
        layers++;
        chk("layer_done_spacing", 32'(cyc - last_p), 32'(maxd + 1));
        chk("round_cnt_at_layer_done", 32'(s_round), 32'd0);
        chk("op_stage_at_layer_done", 32'(s_stg), 32'(STAGE_IDLE));
        layer_cyc = cyc;
      end
      if (layer_cyc >= 0) begin
        cd = '0;
        if (cyc - layer_cyc >= 8) break;
      end else if (hold > 0) begin
        hold--;
      end else begin
        for (int i = 0; i < 4; i++)
          cd[i] = (t >= d[i]) && !(i == 1 && t >= d[1] + 5 && t < d[1] + 10);
      end
      bus_a.conv_done = cd;
    end
    bus_a.conv_done = '0;
    chk("continue_pulse_count", 32'(pulses), 32'd3);
    chk("layer_done_count", 32'(layers), 32'd1);
    chk("busy_after_layer", 32'(s_busy), 32'd0);
    chk("round_cnt_after_layer", 32'(s_round), 32'd0);
  endtask

  task automatic wait_continue();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_cc) begin
        got = 1'b1;
        break;
      end
    end
    chk("continue_seen", 32'(got), 32'd1);
  endtask

  initial begin
    int k, extra, lds;
    n_chk = 0;
    n_fail = 0;
    sel = 1'b0;
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_a.mode_cfg = MODE1;
    bus_a.fload_done = 1'b0;
    bus_a.conv_done = '0;
    bus_a.pe_error = '0;

    vecs[0] = mk(1, 0, MODE1, 0, 0, MODE1, STAGE_IDLE,        0, 0, 1);
    vecs[1] = mk(0, 0, MODE2, 0, 0, MODE1, STAGE_LOAD_FILTER, 1, 0, 1);
    vecs[2] = mk(0, 0, MODE2, 1, 0, MODE1, STAGE_LOAD_FILTER, 0, 0, 1);
    vecs[3] = mk(1, 0, MODE3, 0, 0, MODE1, STAGE_LOAD_FILTER, 0, 0, 1);
    for (int i = 4; i < 14; i++)
      vecs[i] = mk(0, 0, MODE2, 0, 0, MODE1, STAGE_LOAD_FILTER, 0, 0, 1);
    vecs[14] = mk(0, 0, MODE2, 1, 0, MODE1, STAGE_CONV,        0, 0, 1);
    vecs[15] = mk(0, 0, MODE2, 0, 0, MODE1, STAGE_CONV,        0, 1, 1);
    vecs[16] = mk(1, 1, MODE3, 0, 0, MODE1, STAGE_IDLE,        0, 0, 0);
    vecs[17] = mk(0, 0, MODE3, 0, 0, MODE1, STAGE_IDLE,        0, 0, 0);
    vecs[18] = mk(1, 0, MODE3, 0, 1, MODE3, STAGE_IDLE,        0, 0, 1);
    vecs[19] = mk(0, 0, MODE2, 0, 0, MODE3, STAGE_LOAD_FILTER, 1, 0, 1);
    vecs[20] = mk(0, 0, MODE2, 1, 0, MODE3, STAGE_LOAD_FILTER, 0, 0, 1);
    vecs[21] = mk(0, 0, MODE2, 1, 0, MODE3, STAGE_CONV,        0, 0, 1);
    vecs[22] = mk(0, 0, MODE2, 0, 0, MODE3, STAGE_CONV,        0, 1, 1);
    vecs[23] = mk(0, 1, MODE2, 0, 0, MODE3, STAGE_IDLE,        0, 0, 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_mode", 32'(bus_a.mode), 32'(MODE1));
    chk("reset_op_stage", 32'(bus_a.op_stage), 32'(STAGE_IDLE));
    chk("reset_round_cnt", 32'(bus_a.round_cnt), 32'd0);
    chk("reset_busy", 32'(bus_a.busy), 32'd0);
    chk("reset_fault", 32'(bus_a.fault), 32'd0);
    chk("reset_pulses", 32'({bus_a.change_mode, bus_a.fload_start,
                             bus_a.conv_continue, bus_a.layer_done}), 32'd0);

    // Cycle-by-cycle configuration / filter-load sequences.
    for (int i = 0; i < 24; i++) begin
      bus_a.start      = vecs[i].st;
      bus_a.abort      = vecs[i].ab;
      bus_a.mode_cfg   = vecs[i].cfg;
      bus_a.fload_done = vecs[i].fd;
      tick();
      chk($sformatf("vec%0d_change_mode", i), 32'(bus_a.change_mode), 32'(vecs[i].cm));
      chk($sformatf("vec%0d_mode", i), 32'(bus_a.mode), 32'(vecs[i].md));
      chk($sformatf("vec%0d_op_stage", i), 32'(bus_a.op_stage), 32'(vecs[i].stg));
      chk($sformatf("vec%0d_fload_start", i), 32'(bus_a.fload_start), 32'(vecs[i].fs));
      chk($sformatf("vec%0d_conv_continue", i), 32'(bus_a.conv_continue), 32'(vecs[i].cc));
      chk($sformatf("vec%0d_busy", i), 32'(bus_a.busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_round_cnt", i), 32'(bus_a.round_cnt), 32'd0);
      chk($sformatf("vec%0d_fault", i), 32'(bus_a.fault), 32'd0);
    end
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_a.fload_done = 1'b0;

    // Staggered PE completion over three rounds on the long-watchdog instance.
    sel = 1'b1;
    begin_layer(MODE1);
    run_layer(10, 40, 25, 300);
    chk("long_layer_no_fault", 32'(bus_b.fault), 32'd0);
    // The short-watchdog instance saw the same 300-cycle round and must trip.
    chk("short_wd_tripped", 32'(bus_a.fault), 32'd1);
    sel = 1'b0;
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    chk("abort_clears_fault", 32'(bus_a.fault), 32'd0);
    chk("abort_busy", 32'(bus_a.busy), 32'd0);

    // Watchdog: no conv_done at all.
    begin_layer(MODE1);
    wait_continue();
    k = 0;
    extra = 0;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (s_cc) extra++;
      if (s_fault) begin
        k = i;
        break;
      end
    end
    chk("watchdog_fault_cycle", 32'(k), 32'd100);
    chk("watchdog_op_stage", 32'(s_stg), 32'(STAGE_IDLE));
    chk("watchdog_no_extra_continue", 32'(extra), 32'd0);
    repeat (5) tick();
    chk("fault_sticky", 32'(s_fault), 32'd1);
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    chk("abort_after_wd_fault", 32'(s_fault), 32'd0);
    chk("abort_after_wd_busy", 32'(s_busy), 32'd0);
    begin_layer(MODE1);
    run_layer(5, 5, 5, 5);

    // pe_error during WAIT.
    begin_layer(MODE1);
    wait_continue();
    repeat (20) tick();
    bus_a.pe_error = 4'b0100;
    tick();
    bus_a.pe_error = '0;
    chk("pe_error_fault", 32'(s_fault), 32'd1);
    chk("pe_error_op_stage", 32'(s_stg), 32'(STAGE_IDLE));
    bus_a.conv_done = 4'hF;
    extra = 0;
    lds = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_cc) extra++;
      if (s_ld) lds++;
    end
    bus_a.conv_done = '0;
    chk("pe_error_no_continue", 32'(extra), 32'd0);
    chk("pe_error_no_layer_done", 32'(lds), 32'd0);
    chk("pe_error_fault_held", 32'(s_fault), 32'd1);
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;

    // Asynchronous reset in the middle of LOAD.
    bus_a.start = 1'b1;
    bus_a.mode_cfg = MODE3;
    tick();
    bus_a.start = 1'b0;
    tick();
    chk("pre_rst_op_stage", 32'(bus_a.op_stage), 32'(STAGE_LOAD_FILTER));
    chk("pre_rst_mode", 32'(bus_a.mode), 32'(MODE3));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mode", 32'(bus_a.mode), 32'(MODE1));
    chk("async_rst_op_stage", 32'(bus_a.op_stage), 32'(STAGE_IDLE));
    chk("async_rst_busy", 32'(bus_a.busy), 32'd0);
    chk("async_rst_fload_start", 32'(bus_a.fload_start), 32'd0);
    chk("async_rst_fault", 32'(bus_a.fault), 32'd0);
    tick();
    rst = 1'b0;

    // Recovery after reset.
    begin_layer(MODE2);
    chk("recovery_mode", 32'(bus_a.mode), 32'(MODE2));
    run_layer(5, 5, 5, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
